// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, keystroke sequencer state encoding and the
// character-to-scancode lookup helpers.
package ps2_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_PERIOD = 8'h49;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SH_MK  = 3'd1,
    ST_KEY_MK = 3'd2,
    ST_KEY_F0 = 3'd3,
    ST_KEY_BK = 3'd4,
    ST_SH_F0  = 3'd5,
    ST_SH_BK  = 3'd6,
    ST_GAP    = 3'd7
  } key_state_t;

  typedef struct packed {
    logic       supported;
    logic       shift;
    logic [7:0] code;
  } key_map_t;

  // Argument is the offset from '0'; out-of-range offsets return 00.
  function automatic logic [7:0] digit_code(input logic [7:0] d);
    case (d)
      8'd0:    return 8'h45;
      8'd1:    return 8'h16;
      8'd2:    return 8'h1E;
      8'd3:    return 8'h26;
      8'd4:    return 8'h25;
      8'd5:    return 8'h2E;
      8'd6:    return 8'h36;
      8'd7:    return 8'h3D;
      8'd8:    return 8'h3E;
      8'd9:    return 8'h46;
      default: return 8'h00;
    endcase
  endfunction

  // Argument is the offset from 'a' (or 'A').
  function automatic logic [7:0] letter_code(input logic [7:0] l);
    case (l)
      8'd0:    return 8'h1C;
      8'd1:    return 8'h32;
      8'd2:    return 8'h21;
      8'd3:    return 8'h23;
      8'd4:    return 8'h24;
      8'd5:    return 8'h2B;
      8'd6:    return 8'h34;
      8'd7:    return 8'h33;
      8'd8:    return 8'h43;
      8'd9:    return 8'h3B;
      8'd10:   return 8'h42;
      8'd11:   return 8'h4B;
      8'd12:   return 8'h3A;
      8'd13:   return 8'h31;
      8'd14:   return 8'h44;
      8'd15:   return 8'h4D;
      8'd16:   return 8'h15;
      8'd17:   return 8'h2D;
      8'd18:   return 8'h1B;
      8'd19:   return 8'h2C;
      8'd20:   return 8'h3C;
      8'd21:   return 8'h2A;
      8'd22:   return 8'h1D;
      8'd23:   return 8'h22;
      8'd24:   return 8'h35;
      8'd25:   return 8'h1A;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ascii_to_scancode.sv
// Combinational ASCII to PS/2 set-2 key lookup: returns whether the character is
// typeable, whether it needs left shift held, and the key's make code.
module ascii_to_scancode
  import ps2_pkg::*;
(
  input  logic [7:0] ascii,
  output key_map_t   map
);

  always_comb begin
    map = '0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      map = '{supported: 1'b1, shift: 1'b0, code: digit_code(ascii - 8'h30)};
    end else if (ascii >= 8'h61 && ascii <= 8'h7A) begin
      map = '{supported: 1'b1, shift: 1'b0, code: letter_code(ascii - 8'h61)};
    end else if (ascii >= 8'h41 && ascii <= 8'h5A) begin
      map = '{supported: 1'b1, shift: 1'b1, code: letter_code(ascii - 8'h41)};
    end else begin
      // Shifted symbols live on the digit row keys
      case (ascii)
        8'h29:   map = '{supported: 1'b1, shift: 1'b1, code: digit_code(8'd0)};
        8'h21:   map = '{supported: 1'b1, shift: 1'b1, code: digit_code(8'd1)};
        8'h40:   map = '{supported: 1'b1, shift: 1'b1, code: digit_code(8'd2)};
        8'h23:   map = '{supported: 1'b1, shift: 1'b1, code: digit_code(8'd3)};
        8'h24:   map = '{supported: 1'b1, shift: 1'b1, code: digit_code(8'd4)};
        8'h25:   map = '{supported: 1'b1, shift: 1'b1, code: digit_code(8'd5)};
        8'h5E:   map = '{supported: 1'b1, shift: 1'b1, code: digit_code(8'd6)};
        8'h26:   map = '{supported: 1'b1, shift: 1'b1, code: digit_code(8'd7)};
        8'h2A:   map = '{supported: 1'b1, shift: 1'b1, code: digit_code(8'd8)};
        8'h28:   map = '{supported: 1'b1, shift: 1'b1, code: digit_code(8'd9)};
        8'h20:   map = '{supported: 1'b1, shift: 1'b0, code: SC_SPACE};
        8'h2E:   map = '{supported: 1'b1, shift: 1'b0, code: SC_PERIOD};
        default: map = '0;
      endcase
    end
  end

endmodule

// File: rtl/ascii_to_ps2_keys.sv
// Keystroke sequencer: turns one accepted ASCII character into the PS/2 set-2
// make/break byte stream, wrapping shifted characters in left-shift make/break.
//
// state     | meaning
// ST_IDLE   | ready for a character
// ST_SH_MK  | sending left-shift make (12)
// ST_KEY_MK | sending key make
// ST_KEY_F0 | sending break prefix for key
// ST_KEY_BK | sending key code of the break
// ST_SH_F0  | sending break prefix for left shift
// ST_SH_BK  | sending left-shift code of the break
// ST_GAP    | inter-keystroke idle time
module ascii_to_ps2_keys
  import ps2_pkg::*;
#(
  parameter int GAP_CYCLES = 1000,
  parameter int GAP_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] code_byte,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       unsupported,
  output logic       key_done
);

  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

  key_state_t       state;
  key_map_t         map;
  logic [7:0]       key_q;
  logic             shift_q;
  logic [GAP_W-1:0] gap_cnt;

  ascii_to_scancode u_lookup (
    .ascii (ascii_in),
    .map   (map)
  );

  assign ascii_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      code_valid  <= 1'b0;
      code_byte   <= 8'h00;
      unsupported <= 1'b0;
      key_done    <= 1'b0;
      gap_cnt     <= '0;
      key_q       <= 8'h00;
      shift_q     <= 1'b0;
    end else begin
      unsupported <= 1'b0;
      key_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ascii_valid) begin
            if (!map.supported) begin
              unsupported <= 1'b1;
            end else begin
              key_q      <= map.code;
              shift_q    <= map.shift;
              code_valid <= 1'b1;
              if (map.shift) begin
                state     <= ST_SH_MK;
                code_byte <= SC_LSHIFT;
              end else begin
                state     <= ST_KEY_MK;
                code_byte <= map.code;
              end
            end
          end
        end
        ST_SH_MK: if (code_ready) begin
          state     <= ST_KEY_MK;
          code_byte <= key_q;
        end
        ST_KEY_MK: if (code_ready) begin
          state     <= ST_KEY_F0;
          code_byte <= SC_BREAK;
        end
        ST_KEY_F0: if (code_ready) begin
          state     <= ST_KEY_BK;
          code_byte <= key_q;
        end
        ST_KEY_BK: if (code_ready) begin
          if (shift_q) begin
            state     <= ST_SH_F0;
            code_byte <= SC_BREAK;
          end else begin
            code_valid <= 1'b0;
            key_done   <= 1'b1;
            gap_cnt    <= GAP_LOAD;
            state      <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_SH_F0: if (code_ready) begin
          state     <= ST_SH_BK;
          code_byte <= SC_LSHIFT;
        end
        ST_SH_BK: if (code_ready) begin
          code_valid <= 1'b0;
          key_done   <= 1'b1;
          gap_cnt    <= GAP_LOAD;
          state      <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
